// File: rtl/inv_mix_col_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_mix_col_seq
// Brief    : S-AES (Inverse) MixColumns over GF(2^4), one column per cycle,
//            with a valid/ready handshake on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module inv_mix_col_seq #(
    parameter bit FWD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] state_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] state_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_poly_low = 4'h3;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_operand;
    logic [15:0] r_result;
    logic [7:0]  w_col_in;
    logic [7:0]  w_col_out;
    logic [3:0]  w_a;
    logic [3:0]  w_b;

    // Multiply by x modulo x^4+x+1: the dropped x^4 term folds back as x+1.
    function automatic logic [3:0] gf_dbl(input logic [3:0] n);
        gf_dbl = {n[2:0], 1'b0} ^ (n[3] ? c_poly_low : 4'h0);
    endfunction

    function automatic logic [3:0] gf_mul4(input logic [3:0] n);
        gf_mul4 = gf_dbl(gf_dbl(n));
    endfunction

    function automatic logic [3:0] gf_mul9(input logic [3:0] n);
        gf_mul9 = gf_dbl(gf_mul4(n)) ^ n;
    endfunction

    // A single shared column datapath; the state picks which column feeds it.
    assign w_col_in = (r_state == COL1) ? r_operand[7:0] : r_operand[15:8];
    assign w_a      = w_col_in[7:4];
    assign w_b      = w_col_in[3:0];

    generate
        if (FWD == 1'b0) begin : g_inv
            assign w_col_out = {gf_mul9(w_a) ^ gf_dbl(w_b),
                                gf_dbl(w_a)  ^ gf_mul9(w_b)};
        end else begin : g_fwd
            assign w_col_out = {w_a ^ gf_mul4(w_b),
                                gf_mul4(w_a) ^ w_b};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_operand <= 16'h0000;
            r_result  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && in_valid) begin
                r_operand <= state_in;
            end
            if (r_state == COL0) begin
                r_result[15:8] <= w_col_out;
            end
            if (r_state == COL1) begin
                r_result[7:0] <= w_col_out;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = COL0;
            COL0:    w_state_nxt = COL1;
            COL1:    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode the state only, so no input-to-output path.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign state_out = r_result;

endmodule
`default_nettype wire

// File: doc/inv_mix_col_seq.md
Name: inv_mix_col_seq

Overview:
- Sequential S-AES MixColumns stage, one column per cycle.
- Default mode is inverse MixColumns, matrix [[9,2],[2,9]] over GF(2^4) mod x^4+x+1. This is the decryption-path consumer of the GF(2^4) doubling function (x*2 mod x^4+x+1).
- Sits between inverse ShiftRows/AddRoundKey and the next round register.
- Accepts one 16-bit state over a valid/ready handshake, computes column 0 then column 1, and holds the result until the consumer accepts it.

Parameters:
- FWD, 0, selects the matrix: 0 = inverse [[9,2],[2,9]], 1 = forward [[1,4],[4,1]]. Fixed at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state
- state_in  input  16  nibbles s0=[15:12], s1=[11:8], s2=[7:4], s3=[3:0]; column0={s0,s1}, column1={s2,s3}
- out_valid  output  1  state_out is valid
- out_ready  input  1  consumer accepts state_out
- state_out  output  16  result nibbles in the same packing as state_in

Behaviour:
- Arithmetic:
  - GF(2^4) mod x^4+x+1. Doubling is a shift left; if bit3 was set, XOR with 4'h3. Example: 2*8=3, 2*F=D.
  - 4*n = double(double(n)).
  - 9*n = double(double(double(n))) ^ n.
  - All results are 4 bits, no carry.
- Per column {a,b}:
  - Inverse (FWD=0): a'=9a^2b, b'=2a^9b.
  - Forward (FWD=1): a'=a^4b, b'=4a^b.
- FSM states: IDLE, COL0, COL1, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: latch state_in into the operand register and go to COL0.
- COL0: compute column0 from the operand register into result[15:8]; go to COL1.
- COL1: compute column1 into result[7:0]; go to DONE.
- DONE:
  - out_valid=1, in_ready=0, state_out=result.
  - On out_ready at an edge: go to IDLE.
  - out_valid and state_out stay stable while out_ready=0 (no timeout).
- Latency and throughput:
  - Accept edge T -> out_valid high from T+3.
  - Minimum throughput is one state per 4 cycles. There is no accept in the cycle of the DONE->IDLE transition; the next accept is the edge after.
- in_ready is 0 in COL0, COL1 and DONE. in_valid and state_in are ignored there; operand changes after the accept edge do not affect the result.
- state_out is driven from the result register only. Its value outside DONE is don't-care for checking, but it must not change during DONE.
- Reset:
  - rst=1 at an edge forces IDLE and clears the operand and result registers to 16'h0000.
  - Resulting outputs: in_ready=1, out_valid=0, state_out=16'h0000.
  - rst has priority over all handshakes.
  - A reset mid-computation discards the in-flight state; no partial output is produced.
- Outputs are registered or decoded only from the FSM state; there is no combinational path from in_valid/out_ready to the outputs.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, state_out=16'h0000. Hold rst two cycles during DONE -> returns to IDLE, out_valid drops the cycle after the reset edge.
- FWD=0, state_in=16'h1000 -> state_out=16'h9200. state_in=16'h0001 -> 16'h0029. Both with out_valid exactly 3 cycles after the accept edge.
- FWD=0, state_in=16'h1234 -> 16'hD304. state_in=16'hFFFF -> 16'h3333. Exercises the reduction path.
- FWD=1, state_in=16'hFFFF -> 16'h6666, and 16'h1000 -> 16'h1400. Feeding 16'h6666 to a FWD=0 instance returns 16'hFFFF (round trip).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> state_out stable and out_valid held. in_valid pulses with other data are ignored (in_ready=0). Release -> IDLE the next cycle, and the next accept gives the correct new result.
- Back-to-back: in_valid held high with 5 different states and out_ready=1 -> accepts spaced 4 cycles apart, outputs in order, each matching the reference model.
